// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types for the serial 1001 scanner: controller and detector states, pattern.
package seq_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        CtrlIdle  = 2'd0,
        CtrlShift = 2'd1,
        CtrlDone  = 2'd2
    } ctrl_state_e;

    typedef enum logic [2:0] {
        DetIdle  = 3'd0,
        DetS1    = 3'd1,
        DetS10   = 3'd2,
        DetS100  = 3'd3,
        DetS1001 = 3'd4
    } det_state_e;

    localparam logic [3:0] PATTERN = 4'b1001;

endpackage

// File: rtl/seq_scan_ctrl_match.sv
// Non-overlapping 1001 detector, advanced one bit per step.
module seq_match_fsm
    import seq_scan_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic clear,
    input  logic bit_in,
    output logic match
);

    det_state_e state_q, state_d, base;

    // Next-state: clear makes this step start from IDLE instead of the held state.
    always_comb begin
        state_d = state_q;
        base    = clear ? DetIdle : state_q;
        if (step) begin
            unique case (base)
                DetIdle:  state_d = (bit_in == PATTERN[3]) ? DetS1 : DetIdle;
                DetS1:    state_d = (bit_in == PATTERN[2]) ? DetS10 : DetS1;
                DetS10:   state_d = (bit_in == PATTERN[1]) ? DetS100 : DetS1;
                DetS100:  state_d = (bit_in == PATTERN[0]) ? DetS1001 : DetIdle;
                DetS1001: state_d = bit_in ? DetS1 : DetIdle;
                default:  state_d = DetIdle;
            endcase
        end
        // S1001 is only reachable from S100, so entering it is exactly one match.
        match = step && (state_d == DetS1001);
    end

    // Detector state register; persists across words unless cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DetIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-at-a-time 1001 scanner: loads a word, shifts it MSB first through the
// detector, then presents per-word and saturating running match counts.
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TOT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         restart,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(WIDTH+1)-1:0]   out_hits,
    output logic [TOT_W-1:0]             total_hits,
    output logic                         busy
);

    localparam int unsigned HitW = $clog2(WIDTH + 1);
    localparam int unsigned CntW = $clog2(WIDTH);

    ctrl_state_e        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               restart_q, restart_d;
    logic [HitW-1:0]    hits_q, hits_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic               step, clear, match;

    assign step  = (ctrl_q == CtrlShift);
    // Restart only affects the first bit of the word.
    assign clear = restart_q && (cnt_q == '0);

    seq_match_fsm u_match (
        .clk    (clk),
        .reset  (reset),
        .step   (step),
        .clear  (clear),
        .bit_in (shreg_q[WIDTH-1]),
        .match  (match)
    );

    // Controller next-state, shift register, bit counter and hit counters.
    always_comb begin
        ctrl_d    = ctrl_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        restart_d = restart_q;
        hits_d    = hits_q;
        total_d   = total_q;
        unique case (ctrl_q)
            CtrlIdle: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    cnt_d     = '0;
                    hits_d    = '0;
                    restart_d = restart;
                    ctrl_d    = CtrlShift;
                end
            end
            CtrlShift: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CntW'(1);
                if (match) begin
                    hits_d = hits_q + HitW'(1);
                    if (total_q != '1) begin
                        total_d = total_q + TOT_W'(1);
                    end
                end
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    ctrl_d = CtrlDone;
                end
            end
            CtrlDone: begin
                if (out_ready) begin
                    ctrl_d = CtrlIdle;
                end
            end
            default: ctrl_d = CtrlIdle;
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= CtrlIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            restart_q <= 1'b0;
            hits_q    <= '0;
            total_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            hits_q    <= hits_d;
            total_q   <= total_d;
        end
    end

    assign in_ready   = (ctrl_q == CtrlIdle);
    assign out_valid  = (ctrl_q == CtrlDone);
    assign busy       = (ctrl_q != CtrlIdle);
    assign out_hits   = hits_q;
    assign total_hits = total_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl; a second instance with TOT_W=2 shares the stimulus.
module tb_seq_scan_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready, in_ready2;
    logic [WIDTH-1:0] in_data;
    logic             restart;
    logic             out_valid, out_valid2;
    logic             out_ready;
    logic [3:0]       out_hits, out_hits2;
    logic [15:0]      total_hits;
    logic [1:0]       total_hits2;
    logic             busy, busy2;

    int checks = 0;
    int errors = 0;

    seq_scan_ctrl #(.WIDTH(WIDTH), .TOT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .restart    (restart),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hits   (out_hits),
        .total_hits (total_hits),
        .busy       (busy)
    );

    seq_scan_ctrl #(.WIDTH(WIDTH), .TOT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .restart    (restart),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_hits   (out_hits2),
        .total_hits (total_hits2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word, check latency, then optionally stall in DONE before releasing.
    task automatic run_word(input string tag, input logic [7:0] data, input logic rs,
                            input int exp_hits, input int exp_tot, input int exp_tot2,
                            input int hold);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        restart  = rs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~data;
        restart  = ~rs;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".ready_lo"}, 32'(in_ready), 32'd0);
        // Accept edge counts as edge 1; result visible after edge WIDTH+1.
        repeat (WIDTH - 1) @(posedge clk);
        #1;
        check({tag, ".early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".hits"}, 32'(out_hits), 32'(exp_hits));
        check({tag, ".total"}, 32'(total_hits), 32'(exp_tot));
        check({tag, ".total2"}, 32'(total_hits2), 32'(exp_tot2));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'hA5 ^ 8'(h);
            restart  = h[0];
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_hits"}, 32'(out_hits), 32'(exp_hits));
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ready_back"}, 32'(in_ready), 32'd1);
        check({tag, ".valid_lo"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        restart   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.hits", 32'(out_hits), 32'd0);
        check("rst.total", 32'(total_hits), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_word("w1001_0000", 8'b1001_0000, 1'b1, 1, 1, 1, 0);
        run_word("w1001_1001", 8'b1001_1001, 1'b1, 2, 3, 3, 0);
        run_word("w1001_0010", 8'b1001_0010, 1'b1, 1, 4, 3, 0);
        run_word("span_a", 8'b0000_0010, 1'b1, 0, 4, 3, 0);
        run_word("span_b", 8'b0100_0000, 1'b0, 1, 5, 3, 0);
        run_word("nospan_a", 8'b0000_0010, 1'b1, 0, 5, 3, 0);
        run_word("nospan_b", 8'b0100_0000, 1'b1, 0, 5, 3, 0);
        run_word("stall", 8'b1001_0000, 1'b1, 1, 6, 3, 5);

        // Reset during the 4th SHIFT cycle, just before the matching step.
        in_valid = 1'b1;
        in_data  = 8'b1001_1001;
        restart  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid.ready", 32'(in_ready), 32'd1);
        check("rstmid.valid", 32'(out_valid), 32'd0);
        check("rstmid.total", 32'(total_hits), 32'd0);
        check("rstmid.busy", 32'(busy), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("rstmid.no_result", 32'(seen), 32'd0);
        end

        run_word("sat1", 8'b1001_0000, 1'b1, 1, 1, 1, 0);
        run_word("sat2", 8'b1001_0000, 1'b1, 1, 2, 2, 0);
        run_word("sat3", 8'b1001_0000, 1'b1, 1, 3, 3, 0);
        run_word("sat4", 8'b1001_0000, 1'b1, 1, 4, 3, 0);
        run_word("sat5", 8'b1001_0000, 1'b1, 1, 5, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck DUT still produces a summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
